// File: rtl/timer_bank_if.sv
// Control/status bundle between the traffic-light FSM, the clock divider and timer_bank.
// master: the controller side (drives ticks, strobes, durations; reads status).
// slave:  the timer bank itself.
//   enable        tick from the divider (one cycle wide)
//   start         per-channel load/restart strobe
//   value         packed durations, channel i at [i*WIDTH +: WIDTH]
//   auto_reload   per-channel mode, sampled with start (1 = reload on expiry)
//   pause         per-channel level, freezes the countdown
//   abort         per-channel strobe, stops without expiring
//   expired       per-channel one-cycle expiry pulse
//   busy          per-channel running flag
//   remaining     packed current counts
//   divider_reset one-cycle pulse after any start
interface timer_bank_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 4
);
  logic                      enable;
  logic [CHANNELS-1:0]       start;
  logic [CHANNELS*WIDTH-1:0] value;
  logic [CHANNELS-1:0]       auto_reload;
  logic [CHANNELS-1:0]       pause;
  logic [CHANNELS-1:0]       abort;
  logic [CHANNELS-1:0]       expired;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS*WIDTH-1:0] remaining;
  logic                      divider_reset;

  modport master (
    output enable, start, value, auto_reload, pause, abort,
    input  expired, busy, remaining, divider_reset
  );

  modport slave (
    input  enable, start, value, auto_reload, pause, abort,
    output expired, busy, remaining, divider_reset
  );
endinterface

// File: rtl/timer_bank.sv
// Multi-channel countdown timer. Each channel loads a duration on start, counts down on
// enable ticks and pulses expired for one cycle when the duration ends; one-shot or
// auto-reload per channel, with pause, abort, busy and remaining-count readout.
// Ports:
//   clock       system clock, rising edge
//   reset_sync  asynchronous active-high reset
//   bus         timer_bank_if slave modport (see interface header)
module timer_bank #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 4
) (
  input logic        clock,
  input logic        reset_sync,
  timer_bank_if.slave bus
);

  typedef enum logic {StIdle, StRun} state_e;

  logic divider_reset_q;

  // One re-phase pulse per cycle in which any channel was started.
  always_ff @(posedge clock or posedge reset_sync) begin
    if (reset_sync) begin
      divider_reset_q <= 1'b0;
    end else begin
      divider_reset_q <= |bus.start;
    end
  end

  assign bus.divider_reset = divider_reset_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             expired_q, expired_d;
    logic [WIDTH-1:0] value_i;
    logic             tick;

    assign value_i = bus.value[i*WIDTH +: WIDTH];
    assign tick    = (state_q == StRun) && bus.enable && !bus.pause[i];

    always_ff @(posedge clock or posedge reset_sync) begin
      if (reset_sync) begin
        state_q   <= StIdle;
        count_q   <= '0;
        reload_q  <= '0;
        mode_q    <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        count_q   <= count_d;
        reload_q  <= reload_d;
        mode_q    <= mode_d;
        expired_q <= expired_d;
      end
    end

    // Priority: start > abort > tick.
    always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      reload_d  = reload_q;
      mode_d    = mode_q;
      expired_d = 1'b0;
      if (bus.start[i]) begin
        if (value_i != '0) begin
          state_d  = StRun;
          count_d  = value_i;
          reload_d = value_i;
          mode_d   = bus.auto_reload[i];
        end else begin
          // Zero duration expires immediately.
          state_d   = StIdle;
          count_d   = '0;
          expired_d = 1'b1;
        end
      end else if (bus.abort[i]) begin
        if (state_q == StRun) begin
          state_d = StIdle;
          count_d = '0;
        end
      end else if (tick) begin
        if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else if (count_q == WIDTH'(1)) begin
          expired_d = 1'b1;
          if (mode_q) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = StIdle;
          end
        end
        // count_q == 0 while running cannot occur; never wrap.
      end
    end

    assign bus.expired[i]                 = expired_q;
    assign bus.busy[i]                    = (state_q == StRun);
    assign bus.remaining[i*WIDTH +: WIDTH] = count_q;
  end

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

  typedef struct {
    logic [1:0] st;
    logic [3:0] v1;
    logic [3:0] v0;
    logic [1:0] ar;
    logic [1:0] pa;
    logic [1:0] ab;
    logic       en;
    logic [1:0] ex;
    logic [1:0] bz;
    logic [3:0] r1;
    logic [3:0] r0;
    logic       dr;
  } vec_t;

  logic clock = 1'b0;
  logic reset_sync;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  timer_bank_if #(.CHANNELS(2), .WIDTH(4)) bus ();

  timer_bank #(.CHANNELS(2), .WIDTH(4)) dut (
    .clock      (clock),
    .reset_sync (reset_sync),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [1:0] st, input logic [3:0] v1, input logic [3:0] v0,
                              input logic [1:0] ar, input logic [1:0] pa, input logic [1:0] ab,
                              input logic en, input logic [1:0] ex, input logic [1:0] bz,
                              input logic [3:0] r1, input logic [3:0] r0, input logic dr);
    vec_t v;
    v.st = st; v.v1 = v1; v.v0 = v0; v.ar = ar; v.pa = pa; v.ab = ab; v.en = en;
    v.ex = ex; v.bz = bz; v.r1 = r1; v.r0 = r0; v.dr = dr;
    return v;
  endfunction

  task automatic check(input string name, input logic [1:0] ex, input logic [1:0] bz,
                       input logic [3:0] r1, input logic [3:0] r0, input logic dr);
    checks++;
    if (bus.expired !== ex || bus.busy !== bz || bus.remaining !== {r1, r0} ||
        bus.divider_reset !== dr) begin
      errors++;
      $display("FAIL %s: got expired=%b busy=%b remaining=%h divider_reset=%b, want expired=%b busy=%b remaining=%h divider_reset=%b",
               name, bus.expired, bus.busy, bus.remaining, bus.divider_reset, ex, bz, {r1, r0}, dr);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.start       = v.st;
    bus.value       = {v.v1, v.v0};
    bus.auto_reload = v.ar;
    bus.pause       = v.pa;
    bus.abort       = v.ab;
    bus.enable      = v.en;
  endtask

  task automatic step(input string name, input vec_t v);
    drive(v);
    @(posedge clock);
    #1;
    check(name, v.ex, v.bz, v.r1, v.r0, v.dr);
  endtask

  initial begin
    vec_t idle;
    idle = mk(2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
    reset_sync = 1'b1;
    drive(idle);
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
    #2 reset_sync = 1'b0;

    // 1: one-shot, duration 2
    vecs.push_back(mk(2'b01, 0, 2, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01, 0, 2, 1));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01, 0, 2, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01, 0, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0));
    // 2: auto-reload, duration 3, start concurrent with a tick (tick ignored)
    vecs.push_back(mk(2'b01, 0, 3, 2'b01, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0, 3, 1));
    for (int k = 1; k <= 9; k++) begin
      vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, (k % 3 == 0) ? 2'b01 : 2'b00,
                        2'b01, 0, (k % 3 == 0) ? 4'd3 : 4'(3 - k % 3), 0));
    end
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0));
    // 3: ch1 duration 6 with three paused ticks
    vecs.push_back(mk(2'b10, 6, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b10, 6, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b10, 5, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b10, 4, 0, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b10, 2'b00, 1, 2'b00, 2'b10, 4, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b10, 3, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b10, 2, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b10, 1, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0));
    // 4: abort at count 3, abort in idle, zero-duration start
    vecs.push_back(mk(2'b01, 0, 5, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01, 0, 5, 1));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0, 4, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0, 3, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 1, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0));
    // 5: restart at count 1 alongside a tick, joint start, simultaneous expiry, start while paused
    vecs.push_back(mk(2'b01, 0, 2, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01, 0, 2, 1));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0, 1, 0));
    vecs.push_back(mk(2'b01, 0, 5, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0, 5, 1));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0, 4, 0));
    vecs.push_back(mk(2'b11, 2, 2, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b11, 2, 2, 1));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b11, 2, 2, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b11, 1, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(2'b01, 0, 2, 2'b00, 2'b01, 2'b00, 1, 2'b00, 2'b01, 0, 2, 1));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 1, 2'b00, 2'b01, 0, 2, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0));

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // 6: asynchronous reset mid-count, right after a start so divider_reset is high
    step("rst_pre_start", mk(2'b11, 5, 5, 2'b11, 2'b00, 2'b00, 0, 2'b00, 2'b11, 5, 5, 1));
    drive(idle);
    #3 reset_sync = 1'b1;
    #1 check("rst_async", 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
    @(posedge clock);
    #2 reset_sync = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step($sformatf("post_rst%0d", k),
           mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
